// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Pipeline sequencer for the 5-stage myCPU core. Every cycle it decides
//   which pipeline registers advance, hold or load a bubble. It also selects
//   the EX operand forwarding sources, stretches MEM while the Bridge inserts
//   wait states, and halts the core when one access waits too long.
//
//   A private scoreboard shadows {rd, we, ld} of the instructions in EX, MEM
//   and WB, and the source fields of the EX instruction. All stage controls
//   and forwarding selects are combinational from the scoreboard, the FSM
//   state and the current inputs.
//
// Ports
//   cpu_clk, cpu_rst          core clock / async active-low reset
//   id_rs1, id_rs2            ID source register fields
//   id_rs1_used, id_rs2_used  ID instruction reads rs1 / rs2
//   id_rd, id_rf_we           ID destination register and write enable
//   id_is_load                ID instruction is a load
//   ex_redirect               EX instruction changes the PC
//   mem_bus_req, bus_ready    MEM access request / Bridge completes it
//   pc_en .. mem_wb_en        stage register advance enables
//   if_id_flush, id_ex_flush,
//   mem_wb_flush              load a bubble instead of data
//   fwd_a, fwd_b              EX operand source (00 RF, 01 EX/MEM, 10 WB)
//   halted                    core halted after a bus timeout
//   bus_err                   sticky bus timeout flag
//
// state       | meaning
// ST_RUN      | normal issue; bus wait, redirect, load-use resolved here
// ST_BUS_WAIT | MEM access pending, pipe frozen, wait_cnt counting
// ST_HALT     | bus timeout; everything frozen until reset
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic       cpu_clk,
    input  logic       cpu_rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] id_rd,
    input  logic       id_rf_we,
    input  logic       id_is_load,
    input  logic       ex_redirect,
    input  logic       mem_bus_req,
    input  logic       bus_ready,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       id_ex_en,
    output logic       ex_mem_en,
    output logic       mem_wb_en,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       mem_wb_flush,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       halted,
    output logic       bus_err
);

    localparam logic [7:0] LP_TIMEOUT = 8'(BUS_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_BUS_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_wait_cnt;
    logic       r_bus_err;

    logic [4:0] r_ex_rd;
    logic       r_ex_we;
    logic       r_ex_ld;
    logic [4:0] r_ex_rs1;
    logic       r_ex_rs1_used;
    logic [4:0] r_ex_rs2;
    logic       r_ex_rs2_used;
    logic [4:0] r_mem_rd;
    logic       r_mem_we;
    logic       r_mem_ld;
    logic [4:0] r_wb_rd;
    logic       r_wb_we;

    logic       w_freeze;
    logic       w_load_use;
    logic [7:0] w_cnt_inc;
    logic       w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
    logic       w_if_id_flush, w_id_ex_flush, w_mem_wb_flush;
    logic [1:0] w_fwd_a, w_fwd_b;

    // In BUS_WAIT the pending access belongs to the frozen MEM instruction,
    // so only bus_ready matters there.
    assign w_freeze  = (r_state == ST_BUS_WAIT) ? !bus_ready
                                                : (mem_bus_req && !bus_ready);
    assign w_cnt_inc = (r_wait_cnt == 8'hFF) ? r_wait_cnt : r_wait_cnt + 8'd1;

    assign w_load_use = r_ex_we && r_ex_ld && (r_ex_rd != 5'd0) &&
                        ((id_rs1_used && (id_rs1 == r_ex_rd)) ||
                         (id_rs2_used && (id_rs2 == r_ex_rd)));

    always_comb begin
        w_pc_en        = 1'b0;
        w_if_id_en     = 1'b0;
        w_id_ex_en     = 1'b0;
        w_ex_mem_en    = 1'b0;
        w_mem_wb_en    = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_mem_wb_flush = 1'b0;
        if (r_state != ST_HALT) begin
            if (w_freeze) begin
                // WB still retires; MEM/WB takes a bubble so it retires once
                w_mem_wb_flush = 1'b1;
            end else if (ex_redirect) begin
                {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 5'b11111;
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
            end else if (w_load_use) begin
                {w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 3'b111;
                w_id_ex_flush = 1'b1;
            end else begin
                {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 5'b11111;
            end
        end
    end

    // Loads in MEM are excluded: their data only exists from WB onwards.
    function automatic logic [1:0] fwd_sel(
        input logic       used,
        input logic [4:0] rs,
        input logic [4:0] mem_rd,
        input logic       mem_we,
        input logic       mem_ld,
        input logic [4:0] wb_rd,
        input logic       wb_we
    );
        if (!used)
            return 2'b00;
        else if (mem_we && !mem_ld && (mem_rd != 5'd0) && (mem_rd == rs))
            return 2'b01;
        else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        w_fwd_a = fwd_sel(r_ex_rs1_used, r_ex_rs1, r_mem_rd, r_mem_we, r_mem_ld, r_wb_rd, r_wb_we);
        w_fwd_b = fwd_sel(r_ex_rs2_used, r_ex_rs2, r_mem_rd, r_mem_we, r_mem_ld, r_wb_rd, r_wb_we);
    end

    // Outputs are forced quiet while reset is asserted, with no edge needed.
    assign pc_en        = cpu_rst && w_pc_en;
    assign if_id_en     = cpu_rst && w_if_id_en;
    assign id_ex_en     = cpu_rst && w_id_ex_en;
    assign ex_mem_en    = cpu_rst && w_ex_mem_en;
    assign mem_wb_en    = cpu_rst && w_mem_wb_en;
    assign if_id_flush  = cpu_rst && w_if_id_flush;
    assign id_ex_flush  = cpu_rst && w_id_ex_flush;
    assign mem_wb_flush = cpu_rst && w_mem_wb_flush;
    assign fwd_a        = cpu_rst ? w_fwd_a : 2'b00;
    assign fwd_b        = cpu_rst ? w_fwd_b : 2'b00;
    assign halted       = cpu_rst && (r_state == ST_HALT);
    assign bus_err      = r_bus_err;

    // wait_cnt holds the number of wait cycles seen so far, including the
    // current one once it has been clocked; reaching BUS_TIMEOUT halts.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
            r_bus_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_freeze) begin
                        r_wait_cnt <= 8'd1;
                        if (LP_TIMEOUT <= 8'd1) begin
                            r_state   <= ST_HALT;
                            r_bus_err <= 1'b1;
                        end else begin
                            r_state <= ST_BUS_WAIT;
                        end
                    end
                end
                ST_BUS_WAIT: begin
                    if (bus_ready) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= 8'd0;
                    end else begin
                        r_wait_cnt <= w_cnt_inc;
                        if (w_cnt_inc >= LP_TIMEOUT) begin
                            r_state   <= ST_HALT;
                            r_bus_err <= 1'b1;
                        end
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            r_ex_rd       <= 5'd0;
            r_ex_we       <= 1'b0;
            r_ex_ld       <= 1'b0;
            r_ex_rs1      <= 5'd0;
            r_ex_rs1_used <= 1'b0;
            r_ex_rs2      <= 5'd0;
            r_ex_rs2_used <= 1'b0;
            r_mem_rd      <= 5'd0;
            r_mem_we      <= 1'b0;
            r_mem_ld      <= 1'b0;
            r_wb_rd       <= 5'd0;
            r_wb_we       <= 1'b0;
        end else begin
            if (w_id_ex_flush) begin
                r_ex_rd       <= 5'd0;
                r_ex_we       <= 1'b0;
                r_ex_ld       <= 1'b0;
                r_ex_rs1      <= 5'd0;
                r_ex_rs1_used <= 1'b0;
                r_ex_rs2      <= 5'd0;
                r_ex_rs2_used <= 1'b0;
            end else if (w_id_ex_en) begin
                r_ex_rd       <= id_rd;
                r_ex_we       <= id_rf_we;
                r_ex_ld       <= id_is_load;
                r_ex_rs1      <= id_rs1;
                r_ex_rs1_used <= id_rs1_used;
                r_ex_rs2      <= id_rs2;
                r_ex_rs2_used <= id_rs2_used;
            end
            if (w_ex_mem_en) begin
                r_mem_rd <= r_ex_rd;
                r_mem_we <= r_ex_we;
                r_mem_ld <= r_ex_ld;
            end
            if (w_mem_wb_flush) begin
                r_wb_rd <= 5'd0;
                r_wb_we <= 1'b0;
            end else if (w_mem_wb_en) begin
                r_wb_rd <= r_mem_rd;
                r_wb_we <= r_mem_we;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed scenarios with hand-derived expected control words, followed by
//   a randomized run checked against a stage-by-stage pipeline model.
//   Control word layout: {pc,if_id,id_ex,ex_mem,mem_wb enables,
//   if_id,id_ex,mem_wb flushes, fwd_a, fwd_b, halted, bus_err}.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;

    typedef struct packed {
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } instr_t;

    localparam logic [13:0] V_RUN    = 14'b11111_000_00_00_0_0;
    localparam logic [13:0] V_FREEZE = 14'b00000_001_00_00_0_0;
    localparam logic [13:0] V_LU     = 14'b00111_010_00_00_0_0;
    localparam logic [13:0] V_REDIR  = 14'b11111_110_00_00_0_0;
    localparam logic [13:0] V_HALT   = 14'b00000_000_00_00_1_1;

    logic       cpu_clk = 1'b0;
    logic       cpu_rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic       id_rf_we = 1'b0, id_is_load = 1'b0;
    logic       ex_redirect = 1'b0, mem_bus_req = 1'b0, bus_ready = 1'b1;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, mem_wb_flush;
    logic [1:0] fwd_a, fwd_b;
    logic       halted, bus_err;
    logic [13:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    instr_t m_pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
    int     m_mode;       // 0 run, 1 waiting on bus, 2 halted
    int     m_waits;
    logic   m_err;

    pipe_hazard_ctrl #(.BUS_TIMEOUT(TO)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rf_we(id_rf_we), .id_is_load(id_is_load),
        .ex_redirect(ex_redirect), .mem_bus_req(mem_bus_req), .bus_ready(bus_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .bus_err(bus_err)
    );

    assign obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  if_id_flush, id_ex_flush, mem_wb_flush, fwd_a, fwd_b, halted, bus_err};

    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic instr_t mk(input int rs1, input int u1, input int rs2, input int u2,
                                  input int rd, input int we, input int ld);
        instr_t i;
        i.rs1 = 5'(rs1); i.u1 = u1[0]; i.rs2 = 5'(rs2); i.u2 = u2[0];
        i.rd = 5'(rd); i.we = we[0]; i.ld = ld[0];
        return i;
    endfunction

    task automatic set_id(input instr_t i);
        id_rs1 = i.rs1; id_rs1_used = i.u1; id_rs2 = i.rs2; id_rs2_used = i.u2;
        id_rd = i.rd; id_rf_we = i.we; id_is_load = i.ld;
    endtask

    task automatic idle_inputs();
        set_id('0);
        ex_redirect = 1'b0; mem_bus_req = 1'b0; bus_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        cpu_rst = 1'b0;
        tick();
        tick();
        cpu_rst = 1'b1;
        m_pipe[0] = '0; m_pipe[1] = '0; m_pipe[2] = '0;
        m_mode = 0; m_waits = 0; m_err = 1'b0;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] m_fwd(input logic [4:0] rs, input logic used);
        if (!used) return 2'b00;
        if (m_pipe[1].we && !m_pipe[1].ld && m_pipe[1].rd != 0 && m_pipe[1].rd == rs) return 2'b01;
        if (m_pipe[2].we && m_pipe[2].rd != 0 && m_pipe[2].rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic m_bus_stall();
        return (m_mode == 1) ? !bus_ready : (mem_bus_req && !bus_ready);
    endfunction

    function automatic logic [13:0] model_expect();
        logic [7:0] ctl;
        logic       lu;
        instr_t     ex;
        ex  = m_pipe[0];
        lu  = ex.we && ex.ld && ex.rd != 0 &&
              ((id_rs1_used && id_rs1 == ex.rd) || (id_rs2_used && id_rs2 == ex.rd));
        if (m_mode == 2)         ctl = 8'b00000_000;
        else if (m_bus_stall())  ctl = 8'b00000_001;
        else if (ex_redirect)    ctl = 8'b11111_110;
        else if (lu)             ctl = 8'b00111_010;
        else                     ctl = 8'b11111_000;
        return {ctl, m_fwd(ex.rs1, ex.u1), m_fwd(ex.rs2, ex.u2), m_mode == 2, m_err};
    endfunction

    task automatic model_step(input logic [13:0] e);
        instr_t ex_n, mem_n, wb_n, id_i;
        id_i  = '{rs1: id_rs1, u1: id_rs1_used, rs2: id_rs2, u2: id_rs2_used,
                  rd: id_rd, we: id_rf_we, ld: id_is_load};
        wb_n  = e[6] ? '0 : (e[9]  ? m_pipe[1] : m_pipe[2]);
        mem_n = e[10] ? m_pipe[0] : m_pipe[1];
        ex_n  = e[7] ? '0 : (e[11] ? id_i : m_pipe[0]);
        if (m_mode != 2 && m_bus_stall()) begin
            m_waits = (m_mode == 0) ? 1 : m_waits + 1;
            m_mode  = 1;
            if (m_waits >= TO) begin m_mode = 2; m_err = 1'b1; end
        end else if (m_mode == 1) begin
            m_mode = 0; m_waits = 0;
        end
        m_pipe[0] = ex_n; m_pipe[1] = mem_n; m_pipe[2] = wb_n;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        mem_bus_req = 1'b1; bus_ready = 1'b0; ex_redirect = 1'b1;
        set_id(mk(5, 1, 0, 0, 5, 1, 1));
        #2 cpu_rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== 14'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs, 14'd0);
        end
        tick();
        tick();
        idle_inputs();
        cpu_rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== V_RUN) begin
            n_fail++; $display("FAIL reset_release_run: got %b expected %b", obs, V_RUN);
        end
        tick();
    endtask

    task automatic test_load_use();
        instr_t     prod [5];
        instr_t     cons [5];
        logic [13:0] ev  [5];
        // lw x5; add x6,x5,x1 : one bubble, then WB forward to operand a
        set_id(mk(2, 1, 0, 0, 5, 1, 1));
        #1;
        n_checks++;
        if (obs !== V_RUN) begin n_fail++; $display("FAIL lu_lw_issue: got %b expected %b", obs, V_RUN); end
        tick();
        set_id(mk(5, 1, 1, 1, 6, 1, 0));
        #1;
        n_checks++;
        if (obs !== V_LU) begin n_fail++; $display("FAIL lu_stall: got %b expected %b", obs, V_LU); end
        tick();
        #1;
        n_checks++;
        if (obs !== V_RUN) begin n_fail++; $display("FAIL lu_single_bubble: got %b expected %b", obs, V_RUN); end
        tick();
        set_id('0);
        #1;
        n_checks++;
        if (obs !== (V_RUN | 14'b00000_000_10_00_0_0)) begin
            n_fail++; $display("FAIL lu_fwd_wb: got %b expected %b", obs, V_RUN | 14'b00000_000_10_00_0_0);
        end
        tick(); tick(); tick();

        prod[0] = mk(1, 1, 0, 0, 7, 1, 1);  cons[0] = mk(1, 1, 7, 1, 8, 1, 0);  ev[0] = V_LU;
        prod[1] = mk(1, 1, 0, 0, 9, 1, 1);  cons[1] = mk(9, 0, 3, 1, 8, 1, 0);  ev[1] = V_RUN;
        prod[2] = mk(1, 1, 0, 0, 0, 1, 1);  cons[2] = mk(0, 1, 0, 1, 8, 1, 0);  ev[2] = V_RUN;
        prod[3] = mk(1, 1, 0, 0, 5, 1, 0);  cons[3] = mk(5, 1, 5, 1, 8, 1, 0);  ev[3] = V_RUN;
        prod[4] = mk(1, 1, 0, 0, 12, 1, 1); cons[4] = mk(12, 1, 12, 1, 3, 1, 1); ev[4] = V_LU;
        for (int k = 0; k < 5; k++) begin
            set_id(prod[k]);
            tick();
            set_id(cons[k]);
            #1;
            n_checks++;
            if (obs !== ev[k]) begin
                n_fail++; $display("FAIL lu_case%0d: got %b expected %b", k, obs, ev[k]);
            end
            tick();
            set_id('0);
            tick(); tick(); tick();
        end
    endtask

    task automatic test_forwarding();
        instr_t     seq [5][3];
        logic [3:0] efw [5];
        seq[0][0] = mk(0, 1, 0, 0, 3, 1, 0); seq[0][1] = mk(0, 1, 0, 0, 3, 1, 0);
        seq[0][2] = mk(3, 1, 3, 1, 4, 1, 0); efw[0] = 4'b01_01;
        seq[1][0] = mk(0, 1, 0, 0, 7, 1, 0); seq[1][1] = '0;
        seq[1][2] = mk(7, 1, 0, 1, 8, 1, 0); efw[1] = 4'b10_00;
        seq[2][0] = mk(0, 1, 0, 0, 0, 1, 0); seq[2][1] = mk(0, 1, 0, 0, 0, 1, 0);
        seq[2][2] = mk(0, 1, 0, 1, 0, 1, 0); efw[2] = 4'b00_00;
        seq[3][0] = mk(1, 1, 0, 0, 4, 1, 1); seq[3][1] = '0;
        seq[3][2] = mk(4, 1, 2, 1, 9, 1, 0); efw[3] = 4'b10_00;
        seq[4][0] = mk(0, 1, 0, 0, 6, 1, 0); seq[4][1] = mk(0, 1, 0, 0, 5, 1, 0);
        seq[4][2] = mk(6, 1, 5, 1, 9, 1, 0); efw[4] = 4'b10_01;
        for (int k = 0; k < 5; k++) begin
            set_id(seq[k][0]);
            tick();
            set_id(seq[k][1]);
            tick();
            set_id(seq[k][2]);
            #1;
            n_checks++;
            if (obs[13:6] !== V_RUN[13:6]) begin
                n_fail++; $display("FAIL fwd_nostall%0d: got %b expected %b", k, obs[13:6], V_RUN[13:6]);
            end
            tick();
            set_id('0);
            #1;
            n_checks++;
            if (obs !== (V_RUN | {8'd0, efw[k], 2'b00})) begin
                n_fail++; $display("FAIL fwd_case%0d: got %b expected %b", k, obs, V_RUN | {8'd0, efw[k], 2'b00});
            end
            tick(); tick(); tick();
        end
    endtask

    task automatic test_redirect();
        set_id(mk(1, 1, 0, 0, 5, 1, 1));
        tick();
        set_id(mk(5, 1, 0, 0, 6, 1, 0));
        ex_redirect = 1'b1;
        #1;
        n_checks++;
        if (obs !== V_REDIR) begin n_fail++; $display("FAIL redir_over_lu: got %b expected %b", obs, V_REDIR); end
        tick();
        ex_redirect = 1'b0;
        set_id('0);
        #1;
        n_checks++;
        if (obs !== V_RUN) begin n_fail++; $display("FAIL redir_after: got %b expected %b", obs, V_RUN); end
        tick(); tick(); tick();
    endtask

    task automatic test_bus_wait();
        mem_bus_req = 1'b1; bus_ready = 1'b0; ex_redirect = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (obs !== V_FREEZE) begin
                n_fail++; $display("FAIL bus_freeze%0d: got %b expected %b", k, obs, V_FREEZE);
            end
            tick();
        end
        bus_ready = 1'b1;
        #1;
        n_checks++;
        if (obs !== V_REDIR) begin n_fail++; $display("FAIL bus_release_redir: got %b expected %b", obs, V_REDIR); end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (obs !== V_RUN) begin n_fail++; $display("FAIL bus_after: got %b expected %b", obs, V_RUN); end
        tick();
    endtask

    task automatic test_timeout();
        mem_bus_req = 1'b1; bus_ready = 1'b0;
        for (int k = 0; k < TO; k++) begin
            #1;
            n_checks++;
            if (obs !== V_FREEZE) begin
                n_fail++; $display("FAIL tmo_wait%0d: got %b expected %b", k, obs, V_FREEZE);
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            bus_ready = k[0]; ex_redirect = 1'b1;
            #1;
            n_checks++;
            if (obs !== V_HALT) begin
                n_fail++; $display("FAIL tmo_halt%0d: got %b expected %b", k, obs, V_HALT);
            end
            tick();
        end
        cpu_rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== 14'd0) begin n_fail++; $display("FAIL tmo_reset: got %b expected %b", obs, 14'd0); end
        tick();
        idle_inputs();
        cpu_rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== V_RUN) begin n_fail++; $display("FAIL tmo_release: got %b expected %b", obs, V_RUN); end
        tick();
    endtask

    task automatic test_reset_in_wait();
        logic [13:0] e_fz;
        e_fz = V_FREEZE | 14'b00000_000_01_00_0_0;
        set_id(mk(0, 1, 0, 0, 9, 1, 0));
        tick();
        set_id(mk(9, 1, 0, 0, 10, 1, 0));
        tick();
        set_id('0);
        mem_bus_req = 1'b1; bus_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if (obs !== e_fz) begin
                n_fail++; $display("FAIL rstw_freeze%0d: got %b expected %b", k, obs, e_fz);
            end
            tick();
        end
        #2 cpu_rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== 14'd0) begin n_fail++; $display("FAIL rstw_async: got %b expected %b", obs, 14'd0); end
        tick();
        idle_inputs();
        cpu_rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if (obs !== V_RUN) begin
                n_fail++; $display("FAIL rstw_clean%0d: got %b expected %b", k, obs, V_RUN);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [13:0] e;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_rd       = 5'($urandom_range(0, 3));
            id_rs1_used = 1'($urandom % 2);
            id_rs2_used = 1'($urandom % 2);
            id_rf_we    = 1'($urandom % 4 != 0);
            id_is_load  = 1'($urandom % 3 == 0);
            ex_redirect = 1'($urandom % 6 == 0);
            mem_bus_req = 1'($urandom % 3 == 0);
            if (m_mode == 1 && m_waits + 1 >= TO) bus_ready = 1'b1;
            else                                   bus_ready = 1'($urandom % 2);
            #1;
            e = model_expect();
            n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL rand_cycle%0d: got %b expected %b", c, obs, e);
            end
            model_step(e);
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        do_reset();
        test_load_use();
        do_reset();
        test_forwarding();
        do_reset();
        test_redirect();
        do_reset();
        test_bus_wait();
        do_reset();
        test_timeout();
        do_reset();
        test_reset_in_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencer for the 5-stage myCPU core (IF, ID, EX, MEM, WB). It decides every cycle which pipeline registers advance, stall or take a bubble, and it selects the EX-stage operand forwarding sources. It shadows the destination register, write-enable and load flags of each in-flight instruction in its own scoreboard. It also stretches the MEM stage while the Bridge inserts wait states, and halts the core on a bus timeout.

## Interface
Parameters:
- BUS_TIMEOUT, 255: maximum consecutive wait cycles on one MEM access before halting (1..255).

Ports:
- cpu_clk  in  1  core clock; all state updates on the rising edge.
- cpu_rst  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  5  source register fields of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1  the ID instruction reads rs1 / rs2.
- id_rd  in  5  destination register field of the instruction in ID.
- id_rf_we  in  1  the ID instruction writes the register file.
- id_is_load  in  1  the ID instruction is a load (rf_wsel selects DRAM data).
- ex_redirect  in  1  the EX instruction changes the PC (jump, or branch with f=1).
- mem_bus_req  in  1  the MEM instruction accesses the Bridge (load or store).
- bus_ready  in  1  the Bridge completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  the register loads on the next edge (1 = advance).
- if_id_flush, id_ex_flush, mem_wb_flush  out  1  load a bubble (all write-enables 0) instead of data.
- fwd_a, fwd_b  out  2  EX operand source: 00 register file, 01 EX/MEM result, 10 WB write data.
- halted  out  1  the core is halted after a bus timeout.
- bus_err  out  1  sticky flag: a timeout has occurred.

## Operation
- **Scoreboard.** Holds {rd, we, ld, rs1, rs1_used, rs2, rs2_used} for EX, and {rd, we, ld} for MEM and WB.
  - Each entry shifts when its stage enable is 1.
  - A flush loads we=0, ld=0, used=0.
  - A stage with enable=0 and no flush holds its entry.
- **x0 rule.** rd=0 never matches; an entry with rd=0 never causes a hazard or a forward.
- **FSM state RUN.** Checks apply in this priority:
  1. **Bus wait**: mem_bus_req=1 and bus_ready=0. All five enables 0, mem_wb_flush=1 (WB still retires its instruction, MEM/WB takes a bubble), other flushes 0. Go to BUS_WAIT with wait_cnt=1.
  2. **Redirect**: ex_redirect=1. All enables 1, if_id_flush=1, id_ex_flush=1. Load-use is ignored, because the ID instruction is squashed.
  3. **Load-use**: EX entry has we=1, ld=1, rd≠0, and rd equals a used ID source. pc_en=0, if_id_en=0, id_ex_flush=1; the rest advance.
  4. Otherwise all enables are 1 and all flushes are 0.
- **FSM state BUS_WAIT.**
  - bus_ready=1: apply the RUN decision for this cycle, then go to RUN.
  - bus_ready=0: freeze as in bus wait and increment wait_cnt.
  - wait_cnt==BUS_TIMEOUT and bus_ready=0: go to HALT and set bus_err.
- **FSM state HALT.** All enables 0, all flushes 0, halted=1. The only exit is reset.
- **Forwarding** applies to the instruction in EX, per operand. Source selection:
  - 01 if the MEM entry has we=1, ld=0, rd≠0 and rd equals the operand's rs.
  - Else 10 if the WB entry has we=1, rd≠0 and rd matches.
  - Else 00.
  - An unused operand is always 00.
  - A load in MEM never forwards, because the load-use stall guarantees the consumer is at least one cycle behind it.

## Timing
- Outputs are combinational from the scoreboard, FSM state and current inputs. Scoreboard, FSM and wait_cnt update on the rising edge.
- **Latency.**
  - Load-use costs exactly 1 bubble.
  - A taken redirect costs 2 squashed slots.
  - A bus access with N wait cycles freezes the pipe for N cycles.
- **Simultaneous events.**
  - Bus wait with redirect: the freeze wins, and ex_redirect is held by the frozen ID/EX. The redirect is acted on in the first cycle bus_ready=1.
  - Redirect with load-use: the redirect wins.
- **Reset behaviour.** cpu_rst=0 asynchronously clears the scoreboard, sets FSM to RUN and sets wait_cnt=0 and bus_err=0. While in reset, all enables and flushes are 0, fwd_a=fwd_b=00 and halted=0. After release, the first cycle with no hazard has all enables at 1.
- **Mid-stall reset.** Reset in BUS_WAIT or HALT returns the block to RUN with no residual state.
- **Counter.** wait_cnt is 8 bits and saturates; it never wraps.

## Test plan
- **Load-use.** `lw x5` followed by `add x6,x5,x1`: exactly one cycle with pc_en=0, if_id_en=0, id_ex_flush=1. The next cycle has fwd_a=10 and the add result is correct.
- **Forwarding priority.** `addi x3` then `addi x3` then `add x4,x3,x3`: fwd_a=fwd_b=01, because the newest producer in MEM wins over WB. With the register x0 as the destination throughout: fwd=00 and no stalls.
- **Redirect.** Branch taken in EX with a load-use pending in ID: one cycle of if_id_flush=id_ex_flush=1 and pc_en=1, with no stall cycle.
- **Bus wait.** Store with bus_ready low for 3 cycles and ex_redirect=1 held: enables 0 for 3 cycles with mem_wb_flush=1. The flushes for the redirect occur on the 4th cycle.
- **Timeout.** BUS_TIMEOUT=4 and bus_ready held low: halted=1 and bus_err=1 after 4 wait cycles. Enables stay 0 thereafter; asserting cpu_rst clears everything.
- **Reset during BUS_WAIT.** All outputs go to their reset values immediately, with no edge needed. After release: RUN, scoreboard empty, fwd=00.
